// File: rtl/clint_multi_if.sv
// Peripheral bus bundle for clint_multi: select, address, write strobe/size, data in and out.
interface clint_multi_if;
  logic        sel;
  logic [15:0] addr;
  logic [2:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output sel,
    output addr,
    output we,
    output wdata,
    input  rdata
  );

  modport slave (
    input  sel,
    input  addr,
    input  we,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/clint_multi.sv
// Multi-hart RISC-V CLINT: per-hart msip and mtimecmp, one shared prescaled 64-bit mtime,
// registered per-hart timer and software interrupt lines.
module clint_multi #(
  parameter int          NUM_HART  = 2,
  parameter int          PRESC_W   = 8,
  parameter int unsigned PRESC_RST = 0
) (
  input  logic                clk,
  input  logic                rst,
  clint_multi_if.slave        bus,
  output logic [NUM_HART-1:0] int_timer,
  output logic [NUM_HART-1:0] int_soft
);

  logic                wr_en;
  logic                msip_hit;
  logic                cmp_hit;
  logic                ctrl_hit;
  logic                mtime_lo_hit;
  logic                mtime_hi_hit;
  logic [11:0]         msip_idx;
  logic [10:0]         cmp_idx;
  logic                tick;
  logic [31:0]         rdata_c;

  logic [NUM_HART-1:0] msip_q, msip_d;
  logic [63:0]         mtimecmp_q [NUM_HART];
  logic [63:0]         mtimecmp_d [NUM_HART];
  logic                en_q, en_d;
  logic [PRESC_W-1:0]  div_q, div_d;
  logic [PRESC_W-1:0]  count_q, count_d;
  logic [63:0]         mtime_q, mtime_d;
  logic [NUM_HART-1:0] int_timer_q, int_timer_d;
  logic [NUM_HART-1:0] int_soft_q, int_soft_d;

  assign wr_en        = bus.sel & bus.we[2] & (bus.we[1:0] == 2'b10);
  assign msip_hit     = (bus.addr[15:14] == 2'b00) && (bus.addr[1:0] == 2'b00);
  assign cmp_hit      = (bus.addr[15:14] == 2'b01) && (bus.addr[1:0] == 2'b00);
  assign ctrl_hit     = (bus.addr == 16'hBFF0);
  assign mtime_lo_hit = (bus.addr == 16'hBFF8);
  assign mtime_hi_hit = (bus.addr == 16'hBFFC);
  assign msip_idx     = bus.addr[13:2];
  assign cmp_idx      = bus.addr[13:3];

  assign tick = en_q && (count_q == div_q);

  always_comb begin
    msip_d = msip_q;
    for (int h = 0; h < NUM_HART; h++) begin
      mtimecmp_d[h] = mtimecmp_q[h];
      if (wr_en && msip_hit && (msip_idx == 12'(h))) begin
        msip_d[h] = bus.wdata[0];
      end
      if (wr_en && cmp_hit && (cmp_idx == 11'(h))) begin
        if (bus.addr[2]) begin
          mtimecmp_d[h][63:32] = bus.wdata;
        end else begin
          mtimecmp_d[h][31:0] = bus.wdata;
        end
      end
    end
  end

  // A ctrl write restarts the divide count so a new divisor takes effect from a clean phase.
  always_comb begin
    en_d    = en_q;
    div_d   = div_q;
    count_d = count_q;
    if (en_q) begin
      count_d = tick ? '0 : count_q + PRESC_W'(1);
    end
    if (wr_en && ctrl_hit) begin
      en_d    = bus.wdata[0];
      div_d   = bus.wdata[PRESC_W+7:8];
      count_d = '0;
    end
  end

  // A half-word write overrides a coinciding tick; no carry crosses into the other half.
  always_comb begin
    mtime_d = mtime_q;
    if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
    if (wr_en && mtime_lo_hit) begin
      mtime_d = {mtime_q[63:32], bus.wdata};
    end else if (wr_en && mtime_hi_hit) begin
      mtime_d = {bus.wdata, mtime_q[31:0]};
    end
  end

  always_comb begin
    int_soft_d  = msip_q;
    int_timer_d = '0;
    for (int h = 0; h < NUM_HART; h++) begin
      int_timer_d[h] = (mtime_q >= mtimecmp_q[h]);
    end
  end

  always_comb begin
    rdata_c = '0;
    if (bus.sel) begin
      for (int h = 0; h < NUM_HART; h++) begin
        if (msip_hit && (msip_idx == 12'(h))) begin
          rdata_c = {31'b0, msip_q[h]};
        end
        if (cmp_hit && (cmp_idx == 11'(h))) begin
          rdata_c = bus.addr[2] ? mtimecmp_q[h][63:32] : mtimecmp_q[h][31:0];
        end
      end
      if (ctrl_hit) begin
        rdata_c = (32'(div_q) << 8) | {31'b0, en_q};
      end
      if (mtime_lo_hit) begin
        rdata_c = mtime_q[31:0];
      end
      if (mtime_hi_hit) begin
        rdata_c = mtime_q[63:32];
      end
    end
  end

  assign bus.rdata = rdata_c;

  // mtimecmp resets to all-ones so no hart sees a timer interrupt before software programs it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msip_q <= '0;
      for (int h = 0; h < NUM_HART; h++) begin
        mtimecmp_q[h] <= 64'hFFFF_FFFF_FFFF_FFFF;
      end
      en_q        <= 1'b1;
      div_q       <= PRESC_W'(PRESC_RST);
      count_q     <= '0;
      mtime_q     <= '0;
      int_timer_q <= '0;
      int_soft_q  <= '0;
    end else begin
      msip_q <= msip_d;
      for (int h = 0; h < NUM_HART; h++) begin
        mtimecmp_q[h] <= mtimecmp_d[h];
      end
      en_q        <= en_d;
      div_q       <= div_d;
      count_q     <= count_d;
      mtime_q     <= mtime_d;
      int_timer_q <= int_timer_d;
      int_soft_q  <= int_soft_d;
    end
  end

  assign int_timer = int_timer_q;
  assign int_soft  = int_soft_q;

endmodule
